// File: rtl/fadd_pkg.sv
// Shared types and constants for the floating-point adder datapath stages.
package fadd_pkg;

  // Number of register stages in the close path.
  localparam int unsigned CLOSE_STAGES = 3;

  // Default operand widths used by the adder slices.
  localparam int unsigned FADD_FRAC_WIDTH = 36;
  localparam int unsigned FADD_EXP_WIDTH  = 8;

  // Shift-count width for a close-path magnitude. The magnitude is FRAC_WIDTH+1 bits
  // wide, so a count of FRAC_WIDTH+1 must fit.
  function automatic int unsigned shift_width(input int unsigned frac_width);
    return $clog2(frac_width + 2);
  endfunction

  // Close-path result as handed to the rounding stage.
  typedef struct packed {
    logic                       sign;
    logic                       zero;
    logic                       uf;
    logic [FADD_EXP_WIDTH-1:0]  exp;
    logic [FADD_FRAC_WIDTH-1:0] frac;
  } close_res_t;

endpackage

// File: rtl/fadd_lzc.sv
// Combinational leading-zero counter. An all-zero input returns W.
module fadd_lzc #(
  parameter int unsigned W  = 37,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data,
  output logic [CW-1:0] count
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data[i]) begin
        count = CW'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fadd_close_pipe.sv
// Close-path stage of the floating-point adder: effective subtraction with an exponent
// difference of 0 or 1. S1 aligns and subtracts, S2 counts leading zeros and picks the
// shift/exponent, S3 normalises. Each stage has a valid bit with a ready chain.
module fadd_close_pipe
  import fadd_pkg::*;
#(
  parameter int unsigned FRAC_WIDTH = FADD_FRAC_WIDTH,
  parameter int unsigned EXP_WIDTH  = FADD_EXP_WIDTH,
  parameter int unsigned SHW        = shift_width(FRAC_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  exp_a_neq_b,
  input  logic                  far_sign,
  input  logic [EXP_WIDTH-1:0]  exp_f,
  input  logic [FRAC_WIDTH-1:0] elarge_op,
  input  logic [FRAC_WIDTH-1:0] esmall_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FRAC_WIDTH-1:0] close_result,
  output logic [EXP_WIDTH-1:0]  exp_close,
  output logic                  close_sign,
  output logic                  close_zero,
  output logic                  close_uf
);

  // Magnitude width: one guard bit above the significand to catch the borrow.
  localparam int unsigned MW  = FRAC_WIDTH + 1;
  localparam int unsigned EW1 = EXP_WIDTH + 1;

  // ------------------------------------------------------------------------
  // Pipeline control
  // ------------------------------------------------------------------------
  logic [CLOSE_STAGES-1:0] valid_q;
  logic                    load1;
  logic                    load2;
  logic                    load3;

  // A stage loads when it is empty or its successor is loading.
  always_comb begin
    load3 = ~valid_q[2] | out_ready;
    load2 = ~valid_q[1] | load3;
    load1 = ~valid_q[0] | load2;
  end

  assign in_ready  = load1;
  assign out_valid = valid_q[2];

  // Valid bits advance with the load enables; reset empties every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (load1) valid_q[0] <= in_valid;
      if (load2) valid_q[1] <= valid_q[0];
      if (load3) valid_q[2] <= valid_q[1];
    end
  end

  // ------------------------------------------------------------------------
  // S1: alignment and subtraction
  // ------------------------------------------------------------------------
  logic [FRAC_WIDTH-1:0] s_aligned;
  logic [MW-1:0]         l_ext;
  logic [MW-1:0]         s_ext;
  logic [MW-1:0]         diff;
  logic [MW-1:0]         s1_mag;
  logic                  s1_sign;

  // Shift the smaller operand by the exponent difference, subtract, and fold a
  // negative difference back to its magnitude.
  always_comb begin
    s_aligned = exp_a_neq_b ? (esmall_op >> 1) : esmall_op;
    l_ext     = {1'b0, elarge_op};
    s_ext     = {1'b0, s_aligned};
    diff      = l_ext - s_ext;
    s1_mag    = diff[FRAC_WIDTH] ? (s_ext - l_ext) : diff;
    s1_sign   = far_sign ^ diff[FRAC_WIDTH];
  end

  logic [MW-1:0]        s1_mag_q;
  logic                 s1_sign_q;
  logic [EXP_WIDTH-1:0] s1_exp_q;

  // S1 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_mag_q  <= '0;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
    end else if (load1) begin
      s1_mag_q  <= s1_mag;
      s1_sign_q <= s1_sign;
      s1_exp_q  <= exp_f;
    end
  end

  // ------------------------------------------------------------------------
  // S2: leading-zero count, shift and exponent selection
  // ------------------------------------------------------------------------
  logic [SHW-1:0] lz;

  fadd_lzc #(
    .W  (MW),
    .CW (SHW)
  ) u_lzc (
    .data  (s1_mag_q),
    .count (lz)
  );

  logic [EW1-1:0]       ebias;
  logic [EW1-1:0]       lz_ext;
  logic                 s2_is_zero;
  logic [SHW-1:0]       s2_shift;
  logic [EXP_WIDTH-1:0] s2_exp;
  logic                 s2_sign;
  logic                 s2_uf;

  // The shift is limited so the exponent never goes below zero; a zero
  // magnitude is forced to +0.
  always_comb begin
    ebias      = {1'b0, s1_exp_q} + EW1'(1);
    lz_ext     = EW1'(lz);
    s2_is_zero = (s1_mag_q == '0);
    s2_shift   = lz;
    s2_exp     = EXP_WIDTH'(ebias - lz_ext);
    s2_sign    = s1_sign_q;
    s2_uf      = 1'b0;
    if (s2_is_zero) begin
      s2_shift = '0;
      s2_exp   = '0;
      s2_sign  = 1'b0;
    end else if (lz_ext >= ebias) begin
      // exp_f < lz here, so it always fits in the shift-count width.
      s2_shift = SHW'(s1_exp_q);
      s2_exp   = '0;
      s2_uf    = 1'b1;
    end
  end

  logic [MW-1:0]        s2_mag_q;
  logic [SHW-1:0]       s2_shift_q;
  logic [EXP_WIDTH-1:0] s2_exp_q;
  logic                 s2_sign_q;
  logic                 s2_zero_q;
  logic                 s2_uf_q;

  // S2 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_mag_q   <= '0;
      s2_shift_q <= '0;
      s2_exp_q   <= '0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_uf_q    <= 1'b0;
    end else if (load2) begin
      s2_mag_q   <= s1_mag_q;
      s2_shift_q <= s2_shift;
      s2_exp_q   <= s2_exp;
      s2_sign_q  <= s2_sign;
      s2_zero_q  <= s2_is_zero;
      s2_uf_q    <= s2_uf;
    end
  end

  // ------------------------------------------------------------------------
  // S3: normalisation
  // ------------------------------------------------------------------------
  logic [MW-1:0]   shifted;
  close_res_t      s3_res;

  // Logarithmic barrel shifter; each shift-count bit moves the value by 2^k.
  always_comb begin
    shifted = s2_mag_q;
    for (int k = 0; k < SHW; k++) begin
      if (s2_shift_q[k]) begin
        shifted = shifted << (1 << k);
      end
    end
  end

  // Drop the guard bit: the normalised leading one lands in the top result bit.
  always_comb begin
    s3_res      = '0;
    s3_res.sign = s2_sign_q;
    s3_res.zero = s2_zero_q;
    s3_res.uf   = s2_uf_q;
    s3_res.exp  = s2_exp_q;
    s3_res.frac = FRAC_WIDTH'(shifted >> 1);
  end

  close_res_t res_q;

  // Output register; holds while the downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
    end else if (load3) begin
      res_q <= s3_res;
    end
  end

  assign close_result = res_q.frac;
  assign exp_close    = res_q.exp;
  assign close_sign   = res_q.sign;
  assign close_zero   = res_q.zero;
  assign close_uf     = res_q.uf;

endmodule

// File: tb/tb_fadd_close_pipe.sv
// Self-checking bench for fadd_close_pipe: directed vectors, back-pressure, reset
// mid-stream and a randomised run against an arithmetic reference model.
module tb_fadd_close_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        exp_a_neq_b;
  logic        far_sign;
  logic [7:0]  exp_f;
  logic [35:0] elarge_op;
  logic [35:0] esmall_op;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] close_result;
  logic [7:0]  exp_close;
  logic        close_sign;
  logic        close_zero;
  logic        close_uf;

  fadd_close_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .exp_a_neq_b  (exp_a_neq_b),
    .far_sign     (far_sign),
    .exp_f        (exp_f),
    .elarge_op    (elarge_op),
    .esmall_op    (esmall_op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .close_result (close_result),
    .exp_close    (exp_close),
    .close_sign   (close_sign),
    .close_zero   (close_zero),
    .close_uf     (close_uf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] res;
    logic [7:0]  ex;
    logic        sign;
    logic        zero;
    logic        uf;
  } res_t;

  typedef struct {
    logic        neq;
    logic        fs;
    logic [7:0]  ef;
    logic [35:0] l;
    logic [35:0] s;
    res_t        want;
  } vec_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   acc_cnt  = 0;
  int   out_cnt  = 0;

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input logic neq, input logic fs, input logic [7:0] ef,
                                 input logic [35:0] l, input logic [35:0] s);
    res_t r;
    longint unsigned a, b, mag, t;
    int bitlen, lz, e, sh;
    a = l;
    b = neq ? (s / 2) : s;
    if (a >= b) begin
      mag = a - b;
      r.sign = fs;
    end else begin
      mag = b - a;
      r.sign = ~fs;
    end
    r.zero = 1'b0;
    r.uf   = 1'b0;
    if (mag == 0) begin
      r.res  = '0;
      r.ex   = '0;
      r.sign = 1'b0;
      r.zero = 1'b1;
      return r;
    end
    bitlen = 0;
    t = mag;
    while (t != 0) begin
      t = t / 2;
      bitlen++;
    end
    lz = 37 - bitlen;
    e  = int'(ef) + 1;
    if (lz >= e) begin
      sh   = int'(ef);
      r.ex = '0;
      r.uf = 1'b1;
    end else begin
      sh   = lz;
      r.ex = 8'(e - lz);
    end
    r.res = 36'((mag << sh) >> 1);
    return r;
  endfunction

  function automatic vec_t mk(input logic neq, input logic fs, input logic [7:0] ef,
                              input logic [35:0] l, input logic [35:0] s,
                              input logic [35:0] res, input logic [7:0] ex,
                              input logic sign, input logic zero, input logic uf);
    vec_t v;
    v.neq = neq; v.fs = fs; v.ef = ef; v.l = l; v.s = s;
    v.want.res = res; v.want.ex = ex; v.want.sign = sign;
    v.want.zero = zero; v.want.uf = uf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic chk_out(input string tag, input res_t w);
    chk({tag, "_result"}, 64'(close_result), 64'(w.res));
    chk({tag, "_exp"},    64'(exp_close),    64'(w.ex));
    chk({tag, "_sign"},   64'(close_sign),   64'(w.sign));
    chk({tag, "_zero"},   64'(close_zero),   64'(w.zero));
    chk({tag, "_uf"},     64'(close_uf),     64'(w.uf));
  endtask

  task automatic drive(input vec_t v);
    exp_a_neq_b = v.neq;
    far_sign    = v.fs;
    exp_f       = v.ef;
    elarge_op   = v.l;
    esmall_op   = v.s;
  endtask

  task automatic drive_rand();
    logic [35:0] l, d;
    l = 36'({$urandom, $urandom});
    d = 36'($urandom_range(0, 300));
    exp_a_neq_b = 1'($urandom);
    far_sign    = 1'($urandom);
    exp_f       = 8'($urandom);
    elarge_op   = l;
    case ($urandom % 4)
      0:       esmall_op = 36'({$urandom, $urandom});
      1:       esmall_op = l - d;
      2:       esmall_op = l + d;
      default: esmall_op = l;
    endcase
  endtask

  // One cycle of the streaming scoreboard; called at a falling edge with inputs set.
  task automatic step();
    #1;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        chk_out("stream", sb[0]);
        if (out_ready) begin
          void'(sb.pop_front());
          out_cnt++;
        end
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(model(exp_a_neq_b, far_sign, exp_f, elarge_op, esmall_op));
      acc_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single beat through an empty pipeline, checked against hand-derived values.
  task automatic run_single(input vec_t v, input string tag);
    int lat;
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(3));
    chk_out(tag, v.want);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    vec_t bp[5];
    int   guard;

    vecs[0]  = mk(0, 0, 100, 36'h8_0000_0000, 36'h4_0000_0000, 36'h8_0000_0000, 99, 0, 0, 0);
    vecs[1]  = mk(0, 0, 100, 36'h4_0000_0000, 36'h8_0000_0000, 36'h8_0000_0000, 99, 1, 0, 0);
    vecs[2]  = mk(1, 0, 100, 36'h8_0000_0000, 36'h8_0000_0000, 36'h8_0000_0000, 99, 0, 0, 0);
    vecs[3]  = mk(0, 1, 100, 36'h8_0000_0000, 36'h8_0000_0000, 36'h0, 0, 0, 1, 0);
    vecs[4]  = mk(0, 0, 10,  36'h8_0000_0000, 36'h7_FFFF_FFFF, 36'h0_0000_0200, 0, 0, 0, 1);
    vecs[5]  = mk(0, 0, 0,   36'h8_0000_0000, 36'h7_FFFF_FFFF, 36'h0, 0, 0, 0, 1);
    vecs[6]  = mk(0, 1, 255, 36'hF_FFFF_FFFF, 36'h0, 36'hF_FFFF_FFFF, 255, 1, 0, 0);
    vecs[7]  = mk(0, 0, 35,  36'h8_0000_0000, 36'h7_FFFF_FFFF, 36'h4_0000_0000, 0, 0, 0, 1);
    vecs[8]  = mk(0, 0, 36,  36'h8_0000_0000, 36'h7_FFFF_FFFF, 36'h8_0000_0000, 1, 0, 0, 0);
    vecs[9]  = mk(1, 0, 50,  36'h8_0000_0000, 36'hF_FFFF_FFFF, 36'h8_0000_0000, 15, 0, 0, 0);
    vecs[10] = mk(1, 1, 20,  36'h1_0000_0000, 36'hF_0000_0000, 36'hD_0000_0000, 19, 0, 0, 0);

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk_out("rst", '{res: 36'h0, ex: 8'h0, sign: 1'b0, zero: 1'b0, uf: 1'b0});

    // Directed vectors.
    for (int i = 0; i < 11; i++) begin
      run_single(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-pressure: five beats offered while the output is stalled.
    for (int i = 0; i < 5; i++) begin
      drive_rand();
      bp[i].neq = exp_a_neq_b; bp[i].fs = far_sign; bp[i].ef = exp_f;
      bp[i].l = elarge_op; bp[i].s = esmall_op;
    end
    acc_cnt = 0;
    out_cnt = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      drive(bp[acc_cnt < 5 ? acc_cnt : 4]);
      step();
    end
    drive(bp[acc_cnt < 5 ? acc_cnt : 4]);
    #1;
    chk("bp_accepted", 64'(acc_cnt), 64'(3));
    chk("bp_in_ready_low", 64'(in_ready), 64'(0));
    chk("bp_none_out", 64'(out_cnt), 64'(0));
    out_ready = 1'b1;
    guard = 0;
    while (out_cnt < 5 && guard < 30) begin
      if (acc_cnt < 5) begin
        in_valid = 1'b1;
        drive(bp[acc_cnt]);
      end else begin
        in_valid = 1'b0;
      end
      step();
      guard++;
    end
    in_valid = 1'b0;
    chk("bp_out_count", 64'(out_cnt), 64'(5));
    chk("bp_sb_empty", 64'(sb.size()), 64'(0));

    // Reset with three beats in flight.
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      drive_rand();
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_hold_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("midrst_no_stale", 64'(out_valid), 64'(0));
      step();
    end
    run_single(vecs[4], "post_rst");

    // Randomised traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 10) < 7;
      out_ready = ($urandom % 10) < 7;
      drive_rand();
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    chk("rand_drained", 64'(sb.size()), 64'(0));
    chk("rand_idle", 64'(out_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
